// File: rtl/sd_resp_rx.sv
// sd_resp_rx: SD CMD-line response receiver with framing/CRC7 check and byte-readable buffer
//   clk, rst       : SD bit clock (CMD sampled on posedge), sync active-high reset
//   arm            : pulse from command transmitter, latches long_resp/skip_crc
//   i_sd_cmd       : CMD line level
//   rd_addr/rd_data: byte read of the captured frame (0..16, zero beyond)
//   busy/done      : receiver active / one-cycle completion pulse
//   status         : {timeout, crc_err, frame_err, valid}, sticky until next arm
module sd_resp_rx #(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       arm,
   input  logic       long_resp,
   input  logic       skip_crc,
   input  logic       i_sd_cmd,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_data,
   output logic       busy,
   output logic       done,
   output logic [3:0] status
);
   typedef enum logic [1:0] {IDLE, WAIT, RECV, CHECK} state_t;
   state_t state, state_nx;
   logic [135:0] resp;
   logic [6:0] crc, crc_nx;
   logic [15:0] wcnt;
   logic [7:0] bcnt, last_idx;
   logic long_q, skip_q, crc_en, expired, frame_err, crc_err;
   assign last_idx = long_q ? 8'd135 : 8'd47;
   assign expired = wcnt == 16'(TIMEOUT_CYC - 1);
   // bcnt k carries frame bit N-1-k; CRC covers bits 47..8 (short) or 127..8 (R2)
   assign crc_en = long_q ? (bcnt >= 8'd8 && bcnt <= 8'd127) : (bcnt <= 8'd39);
   assign crc_nx = {crc[5:0], 1'b0} ^ ({7{crc[6] ^ i_sd_cmd}} & 7'h09);
   assign frame_err = (long_q ? resp[135] : resp[47]) | (long_q ? resp[134] : resp[46]) | !resp[0];
   assign crc_err = !skip_q && (crc != resp[7:1]);
   assign busy = state != IDLE;
   assign rd_data = (rd_addr <= 5'd16) ? 8'(resp >> {rd_addr, 3'b000}) : 8'h00;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  state_nx = arm ? WAIT : IDLE;
         WAIT:  state_nx = !i_sd_cmd ? RECV : expired ? IDLE : WAIT;
         RECV:  state_nx = (bcnt == last_idx) ? CHECK : RECV;
         CHECK: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= state_nx;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         resp <= '0;
         status <= '0;
         done <= 1'b0;
         crc <= '0;
         wcnt <= '0;
         bcnt <= '0;
         long_q <= 1'b0;
         skip_q <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (arm) begin
               long_q <= long_resp;
               skip_q <= skip_crc;
               resp <= '0;
               status <= '0;
               crc <= '0;
               wcnt <= '0;
               bcnt <= '0;
            end
            WAIT: if (!i_sd_cmd) begin
               // start bit shifts in at bit 0 and reaches bit N-1 after the frame
               resp <= {resp[134:0], i_sd_cmd};
               bcnt <= 8'd1;
            end else begin
               wcnt <= wcnt + 16'd1;
               if (expired) begin
                  status <= 4'b1000;
                  done <= 1'b1;
               end
            end
            RECV: begin
               resp <= {resp[134:0], i_sd_cmd};
               bcnt <= bcnt + 8'd1;
               if (crc_en) crc <= crc_nx;
            end
            CHECK: begin
               status <= {1'b0, crc_err, frame_err, !crc_err && !frame_err};
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule
